// File: rtl/phase_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer with Moore outputs and bounded ROM/RAM handshakes.
// Stalls in FETCH until rom_ack and in WRITEBACK until ram_ack; a missing ack faults into HALT.
module phase_sequencer #(
  parameter logic [15:0] PC_RESET    = 16'h0000,
  parameter int          ACK_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        halt_req,
  output logic        rom_req,
  output logic [15:0] rom_addr,
  input  logic        rom_ack,
  input  logic [15:0] instr_in,
  output logic [15:0] instr,
  output logic        decode_en,
  output logic        exec_en,
  output logic        wb_en,
  input  logic        reg_m_en,
  output logic        ram_req,
  input  logic        ram_ack,
  input  logic        set_pc,
  input  logic [15:0] jump_target,
  output logic [15:0] pc,
  output logic [2:0]  phase,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_count;
  logic [15:0] r_wait;
  logic        r_fault;
  logic        r_mem_wait;
  logic        r_halt_pend;
  logic        w_fetch_done;
  logic        w_wb_done;
  logic        w_timeout;
  logic        w_waiting;
  logic        w_in_instr;

  // The write request is captured leaving EXECUTE so ram_req stays a pure function of registered state.
  assign w_waiting  = (r_state == S_FETCH) || ((r_state == S_WRITEBACK) && r_mem_wait);
  assign w_in_instr = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                      (r_state == S_EXECUTE) || (r_state == S_WRITEBACK);

  always_comb begin
    w_next       = r_state;
    w_fetch_done = 1'b0;
    w_wb_done    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (rom_ack) begin
          w_fetch_done = 1'b1;
          w_next       = S_DECODE;
        end else if (r_wait == WAIT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_DECODE:  w_next = S_EXECUTE;
      S_EXECUTE: w_next = S_WRITEBACK;
      S_WRITEBACK: begin
        if (!r_mem_wait || ram_ack) begin
          w_wb_done = 1'b1;
          if (halt_req || r_halt_pend) w_next = S_HALT;
          else if (!run)               w_next = S_IDLE;
          else                         w_next = S_FETCH;
        end else if (r_wait == WAIT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pc        <= PC_RESET;
      r_instr     <= 16'h0000;
      r_count     <= 16'h0000;
      r_wait      <= 16'h0000;
      r_fault     <= 1'b0;
      r_mem_wait  <= 1'b0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_fetch_done) r_instr <= instr_in;
      if (w_wb_done) begin
        r_pc    <= set_pc ? jump_target : r_pc + 16'd1;
        r_count <= r_count + 16'd1;
      end
      if (w_timeout) r_fault <= 1'b1;
      // Any state change restarts the wait count, covering entry to FETCH and to a WRITEBACK wait.
      if (w_next != r_state) r_wait <= 16'h0000;
      else if (w_waiting)    r_wait <= r_wait + 16'd1;
      if (r_state == S_EXECUTE) r_mem_wait <= reg_m_en;
      else if (w_wb_done)       r_mem_wait <= 1'b0;
      if (w_wb_done || w_timeout)     r_halt_pend <= 1'b0;
      else if (halt_req && w_in_instr) r_halt_pend <= 1'b1;
    end
  end

  assign rom_req     = (r_state == S_FETCH);
  assign rom_addr    = r_pc;
  assign instr       = r_instr;
  assign decode_en   = (r_state == S_DECODE);
  assign exec_en     = (r_state == S_EXECUTE);
  assign wb_en       = (r_state == S_WRITEBACK);
  assign ram_req     = (r_state == S_WRITEBACK) && r_mem_wait;
  assign pc          = r_pc;
  assign phase       = r_state;
  assign halted      = (r_state == S_HALT);
  assign fault       = r_fault;
  assign instr_count = r_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_phase_sequencer;
  logic        clk;
  logic        rst;
  logic        run;
  logic        halt_req;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ack;
  logic [15:0] instr_in;
  logic [15:0] instr;
  logic        decode_en;
  logic        exec_en;
  logic        wb_en;
  logic        reg_m_en;
  logic        ram_req;
  logic        ram_ack;
  logic        set_pc;
  logic [15:0] jump_target;
  logic [15:0] pc;
  logic [2:0]  phase;
  logic        halted;
  logic        fault;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  phase_sequencer #(.PC_RESET(16'h0000), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .instr_in(instr_in),
    .instr(instr), .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en),
    .reg_m_en(reg_m_en), .ram_req(ram_req), .ram_ack(ram_ack), .set_pc(set_pc),
    .jump_target(jump_target), .pc(pc), .phase(phase), .halted(halted),
    .fault(fault), .instr_count(instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; halt_req = 1'b0; rom_ack = 1'b0; instr_in = 16'h0000;
    reg_m_en = 1'b0; ram_ack = 1'b0; set_pc = 1'b0; jump_target = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0; run = 1'b1; rom_ack = 1'b1; ram_ack = 1'b1; halt_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({phase, pc, instr, instr_count} !== {3'd0, 16'h0000, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state: phase=%0d pc=%h instr=%h cnt=%h, required 0/0000/0000/0000", phase, pc, instr, instr_count);
    end
    checks++;
    if ({rom_req, decode_en, exec_en, wb_en, ram_req, halted, fault} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000000", {rom_req, decode_en, exec_en, wb_en, ram_req, halted, fault});
    end
    halt_req = 1'b0;
  endtask

  task automatic test_basic();
    logic [2:0]  exp_phase;
    logic [15:0] exp_pc;
    do_reset();
    run = 1'b1; rom_ack = 1'b1; ram_ack = 1'b1; instr_in = 16'h1234;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_phase = 3'(1 + k % 4);
      exp_pc    = 16'(k / 4);
      checks++;
      if ({phase, pc, instr_count, rom_addr} !== {exp_phase, exp_pc, exp_pc, exp_pc}) begin
        errors++;
        $display("FAIL basic_seq[%0d]: phase=%0d pc=%h cnt=%h addr=%h, required %0d/%h/%h/%h",
                 k, phase, pc, instr_count, rom_addr, exp_phase, exp_pc, exp_pc, exp_pc);
      end
      checks++;
      if ({rom_req, decode_en, exec_en, wb_en, ram_req} !== (5'b10000 >> (k % 4))) begin
        errors++;
        $display("FAIL basic_strobes[%0d]: got %b, required %b", k,
                 {rom_req, decode_en, exec_en, wb_en, ram_req}, 5'b10000 >> (k % 4));
      end
    end
    @(negedge clk);
    checks++;
    if ({phase, pc, instr_count, instr} !== {3'd1, 16'd3, 16'd3, 16'h1234}) begin
      errors++;
      $display("FAIL basic_end: phase=%0d pc=%h cnt=%h instr=%h, required 1/0003/0003/1234", phase, pc, instr_count, instr);
    end
  endtask

  task automatic test_rom_delay();
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if ({phase, rom_req, instr} !== {3'd1, 1'b1, 16'h0000}) begin
        errors++;
        $display("FAIL rom_wait[%0d]: phase=%0d rom_req=%b instr=%h, required 1/1/0000", c, phase, rom_req, instr);
      end
      if (c == 4) begin
        rom_ack = 1'b1; instr_in = 16'h8A3F;
      end
    end
    @(negedge clk);
    checks++;
    if ({phase, rom_req, decode_en, instr} !== {3'd2, 1'b0, 1'b1, 16'h8A3F}) begin
      errors++;
      $display("FAIL rom_done: phase=%0d rom_req=%b dec=%b instr=%h, required 2/0/1/8A3F", phase, rom_req, decode_en, instr);
    end
    instr_in = 16'h5555;
    @(negedge clk);
    rom_ack = 1'b0;
    checks++;
    if ({phase, instr} !== {3'd3, 16'h8A3F}) begin
      errors++;
      $display("FAIL rom_ack_ignored: phase=%0d instr=%h, required 3/8A3F", phase, instr);
    end
  endtask

  task automatic test_mem_jump();
    do_reset();
    run = 1'b1; rom_ack = 1'b1; reg_m_en = 1'b1; set_pc = 1'b1; jump_target = 16'h0040;
    repeat (3) @(negedge clk);
    for (int w = 1; w <= 3; w++) begin
      @(negedge clk);
      checks++;
      if ({phase, wb_en, ram_req, pc} !== {3'd4, 1'b1, 1'b1, 16'h0000}) begin
        errors++;
        $display("FAIL mem_wait[%0d]: phase=%0d wb=%b ram_req=%b pc=%h, required 4/1/1/0000", w, phase, wb_en, ram_req, pc);
      end
      if (w == 3) ram_ack = 1'b1;
    end
    @(negedge clk);
    checks++;
    if ({phase, wb_en, ram_req, pc, instr_count, fault} !== {3'd1, 1'b0, 1'b0, 16'h0040, 16'd1, 1'b0}) begin
      errors++;
      $display("FAIL mem_jump_done: phase=%0d wb=%b ram_req=%b pc=%h cnt=%h fault=%b, required 1/0/0/0040/0001/0",
               phase, wb_en, ram_req, pc, instr_count, fault);
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    run = 1'b1; rom_ack = 1'b1; ram_ack = 1'b1; set_pc = 1'b1; jump_target = 16'hFFFF;
    repeat (5) @(negedge clk);
    set_pc = 1'b0;
    checks++;
    if ({phase, pc} !== {3'd1, 16'hFFFF}) begin
      errors++;
      $display("FAIL wrap_setup: phase=%0d pc=%h, required 1/FFFF", phase, pc);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({phase, pc, instr_count} !== {3'd1, 16'h0000, 16'd2}) begin
      errors++;
      $display("FAIL pc_wrap: phase=%0d pc=%h cnt=%h, required 1/0000/0002", phase, pc, instr_count);
    end
  endtask

  task automatic test_rom_timeout();
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if ({phase, rom_req, fault} !== {3'd1, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL rom_to_wait[%0d]: phase=%0d rom_req=%b fault=%b, required 1/1/0", c, phase, rom_req, fault);
      end
    end
    @(negedge clk);
    checks++;
    if ({phase, halted, fault, rom_req, pc, instr_count} !== {3'd5, 1'b1, 1'b1, 1'b0, 16'h0000, 16'd0}) begin
      errors++;
      $display("FAIL rom_timeout: phase=%0d halted=%b fault=%b rom_req=%b pc=%h cnt=%h, required 5/1/1/0/0000/0000",
               phase, halted, fault, rom_req, pc, instr_count);
    end
    rom_ack = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({phase, halted, rom_req, decode_en} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL halt_sticky: phase=%0d halted=%b rom_req=%b dec=%b, required 5/1/0/0", phase, halted, rom_req, decode_en);
    end
  endtask

  task automatic test_ack_at_limit();
    do_reset();
    run = 1'b1; instr_in = 16'hC0DE;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 8) rom_ack = 1'b1;
    end
    @(negedge clk);
    checks++;
    if ({phase, fault, halted, instr} !== {3'd2, 1'b0, 1'b0, 16'hC0DE}) begin
      errors++;
      $display("FAIL ack_at_limit: phase=%0d fault=%b halted=%b instr=%h, required 2/0/0/C0DE", phase, fault, halted, instr);
    end
  endtask

  task automatic test_ram_timeout();
    do_reset();
    run = 1'b1; rom_ack = 1'b1; reg_m_en = 1'b1;
    repeat (3) @(negedge clk);
    for (int w = 1; w <= 8; w++) begin
      @(negedge clk);
      checks++;
      if ({phase, ram_req} !== {3'd4, 1'b1}) begin
        errors++;
        $display("FAIL ram_to_wait[%0d]: phase=%0d ram_req=%b, required 4/1", w, phase, ram_req);
      end
    end
    @(negedge clk);
    checks++;
    if ({phase, fault, ram_req, wb_en, pc, instr_count} !== {3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0}) begin
      errors++;
      $display("FAIL ram_timeout: phase=%0d fault=%b ram_req=%b wb=%b pc=%h cnt=%h, required 5/1/0/0/0000/0000",
               phase, fault, ram_req, wb_en, pc, instr_count);
    end
  endtask

  task automatic test_stop_run();
    do_reset();
    run = 1'b1; rom_ack = 1'b1;
    repeat (2) @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({phase, pc, instr_count} !== {3'd0, 16'd1, 16'd1}) begin
      errors++;
      $display("FAIL stop_run: phase=%0d pc=%h cnt=%h, required 0/0001/0001", phase, pc, instr_count);
    end
    @(negedge clk);
    checks++;
    if ({phase, rom_req} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL idle_hold: phase=%0d rom_req=%b, required 0/0", phase, rom_req);
    end
    run = 1'b1; rom_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({phase, rom_req, pc} !== {3'd0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_mid_fetch: phase=%0d rom_req=%b pc=%h, required 0/0/0000", phase, rom_req, pc);
    end
  endtask

  task automatic test_halt_run();
    do_reset();
    run = 1'b1; rom_ack = 1'b1; instr_in = 16'h7E01;
    repeat (3) @(negedge clk);
    halt_req = 1'b1; run = 1'b0;
    @(negedge clk);
    checks++;
    if ({phase, wb_en} !== {3'd4, 1'b1}) begin
      errors++;
      $display("FAIL halt_wb: phase=%0d wb=%b, required 4/1", phase, wb_en);
    end
    @(negedge clk);
    checks++;
    if ({phase, halted, fault, pc, instr_count, rom_req, wb_en} !== {3'd5, 1'b1, 1'b0, 16'd1, 16'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL halt_retire: phase=%0d halted=%b fault=%b pc=%h cnt=%h rom_req=%b wb=%b, required 5/1/0/0001/0001/0/0",
               phase, halted, fault, pc, instr_count, rom_req, wb_en);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({phase, halted, fault, pc, instr_count, instr} !== {3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL halt_reset: phase=%0d halted=%b fault=%b pc=%h cnt=%h instr=%h, required 0/0/0/0000/0000/0000",
               phase, halted, fault, pc, instr_count, instr);
    end
    halt_req = 1'b0; rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; halt_req = 1'b0; rom_ack = 1'b0; instr_in = 16'h0000;
    reg_m_en = 1'b0; ram_ack = 1'b0; set_pc = 1'b0; jump_target = 16'h0000;
    test_reset();
    test_basic();
    test_rom_delay();
    test_mem_jump();
    test_pc_wrap();
    test_rom_timeout();
    test_ack_at_limit();
    test_ram_timeout();
    test_stop_run();
    test_halt_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
